// File: rtl/vedic_mul_pipe.sv
// ---------------------------------------------------------------------------
// vedic_mul_pipe
//
// Three-stage pipelined Vedic multiplier with a valid/ready stream interface.
// The operands are split into four half-width partial products. Each partial
// product comes from a recursive Vedic sub-multiplier that bottoms out at 2x2.
// A Vedic adder stage then recombines them. The block sustains one product
// per clock. When the consumer holds off, the whole pipe freezes in place.
//
// Optional feature macro: VEDIC_SIGNED_EN
//   When defined, the op_signed port exists and two's-complement operands are
//   supported. When undefined, the block is unsigned-only and has the same
//   timing.
//
// Parameters
//   WIDTH      operand width; must be 4, 8, 16 or 32
//
// Ports
//   CLK        clock, all state changes on the rising edge
//   RST_n      asynchronous active-low reset
//   A, B       multiplicand / multiplier (WIDTH bits)
//   in_valid   A/B carry an operand pair this cycle
//   in_ready   block accepts an operand pair this cycle
//   op_signed  treat A/B as two's complement (VEDIC_SIGNED_EN only)
//   Q          product (2*WIDTH bits)
//   out_valid  Q holds a valid product
//   out_ready  consumer accepts Q this cycle
//   busy       any pipeline stage holds a valid operation
// ---------------------------------------------------------------------------

// Recursive combinational Vedic multiplier: W x W -> 2W bits, W a power of two.
module VedicCore #(
  parameter int W = 2
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  if (W == 2) begin : gBase
    // 2x2 base case written as the classic vertical-and-crosswise half-adder
    // network. The two cross terms meet in a half adder, and the carry from
    // that adder ripples into the top partial product.
    logic cross0;
    logic cross1;
    logic carry1;
    logic top;

    assign cross0 = a_i[1] & b_i[0];
    assign cross1 = a_i[0] & b_i[1];
    assign carry1 = cross0 & cross1;
    assign top    = a_i[1] & b_i[1];
    assign p_o[0] = a_i[0] & b_i[0];
    assign p_o[1] = cross0 ^ cross1;
    assign p_o[2] = top ^ carry1;
    assign p_o[3] = top & carry1;
  end else begin : gSplit
    // Split into four half-width products and recombine them. The sum is kept
    // one bit wider than the result. That top bit is always zero for an exact
    // product, so it is simply dropped.
    localparam int H = W / 2;

    logic [W-1:0] pp0;
    logic [W-1:0] pp1;
    logic [W-1:0] pp2;
    logic [W-1:0] pp3;
    logic [2*W:0] sum;
    logic         unusedTop;

    VedicCore #(.W(H)) uLL (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(pp0));
    VedicCore #(.W(H)) uHL (.a_i(a_i[W-1:H]), .b_i(b_i[H-1:0]), .p_o(pp1));
    VedicCore #(.W(H)) uLH (.a_i(a_i[H-1:0]), .b_i(b_i[W-1:H]), .p_o(pp2));
    VedicCore #(.W(H)) uHH (.a_i(a_i[W-1:H]), .b_i(b_i[W-1:H]), .p_o(pp3));

    assign sum = {{(W+1){1'b0}}, pp0}
               + (({{(W+1){1'b0}}, pp1} + {{(W+1){1'b0}}, pp2}) << H)
               + ({{(W+1){1'b0}}, pp3} << W);
    assign {unusedTop, p_o} = sum;
  end

endmodule

module vedic_mul_pipe #(
  parameter int WIDTH = 8
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               in_valid,
  output logic               in_ready,
`ifdef VEDIC_SIGNED_EN
  input  logic               op_signed,
`endif
  output logic [2*WIDTH-1:0] Q,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  localparam int H = WIDTH / 2;

  // Only power-of-two widths from 4 to 32 split cleanly down to 2x2 cores.
  if (!(WIDTH == 4 || WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : gBadWidth
    $error("vedic_mul_pipe: WIDTH must be 4, 8, 16 or 32");
  end

  logic                 stall;
  logic                 advance;

  logic [WIDTH-1:0]     s1a_d;
  logic [WIDTH-1:0]     s1b_d;
  logic [WIDTH-1:0]     s1a_q;
  logic [WIDTH-1:0]     s1b_q;
  logic                 s1Valid_q;

  logic [WIDTH-1:0]     pp0_d;
  logic [WIDTH-1:0]     pp1_d;
  logic [WIDTH-1:0]     pp2_d;
  logic [WIDTH-1:0]     pp3_d;
  logic [WIDTH-1:0]     pp0_q;
  logic [WIDTH-1:0]     pp1_q;
  logic [WIDTH-1:0]     pp2_q;
  logic [WIDTH-1:0]     pp3_q;
  logic                 s2Valid_q;

  logic [2*WIDTH:0]     sum;
  logic [2*WIDTH:0]     sumSigned;
  logic [2*WIDTH-1:0]   prod_d;
  logic [2*WIDTH-1:0]   prod_q;
  logic                 unusedTop;
  logic                 s3Valid_q;

  // The pipe freezes only when a finished product is waiting on the consumer.
  // in_ready depends only on the output side, so it never loops back through
  // in_valid.
  assign stall    = s3Valid_q && !out_ready;
  assign advance  = !stall;
  assign in_ready = !stall;

`ifdef VEDIC_SIGNED_EN
  logic sign1_d;
  logic sign1_q;
  logic sign2_q;

  // In signed mode the unsigned core sees magnitudes. The most negative
  // value maps to 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  always_comb begin
    s1a_d   = (op_signed && A[WIDTH-1]) ? -A : A;
    s1b_d   = (op_signed && B[WIDTH-1]) ? -B : B;
    sign1_d = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
  end

  // The result sign travels alongside the data and is applied in S3.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
    end else if (advance) begin
      sign1_q <= sign1_d;
      sign2_q <= sign1_q;
    end
  end

  assign sumSigned = sign2_q ? -sum : sum;
`else
  always_comb begin
    s1a_d = A;
    s1b_d = B;
  end

  assign sumSigned = sum;
`endif

  // S1 operand register. Data may load junk when in_valid is low; the valid
  // bit is what marks a real operation.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      s1a_q     <= '0;
      s1b_q     <= '0;
      s1Valid_q <= 1'b0;
    end else if (advance) begin
      s1a_q     <= s1a_d;
      s1b_q     <= s1b_d;
      s1Valid_q <= in_valid;
    end
  end

  VedicCore #(.W(H)) uPp0 (.a_i(s1a_q[H-1:0]),     .b_i(s1b_q[H-1:0]),     .p_o(pp0_d));
  VedicCore #(.W(H)) uPp1 (.a_i(s1a_q[WIDTH-1:H]), .b_i(s1b_q[H-1:0]),     .p_o(pp1_d));
  VedicCore #(.W(H)) uPp2 (.a_i(s1a_q[H-1:0]),     .b_i(s1b_q[WIDTH-1:H]), .p_o(pp2_d));
  VedicCore #(.W(H)) uPp3 (.a_i(s1a_q[WIDTH-1:H]), .b_i(s1b_q[WIDTH-1:H]), .p_o(pp3_d));

  // S2 registers the four half-width partial products.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pp0_q     <= '0;
      pp1_q     <= '0;
      pp2_q     <= '0;
      pp3_q     <= '0;
      s2Valid_q <= 1'b0;
    end else if (advance) begin
      pp0_q     <= pp0_d;
      pp1_q     <= pp1_d;
      pp2_q     <= pp2_d;
      pp3_q     <= pp3_d;
      s2Valid_q <= s1Valid_q;
    end
  end

  // Vedic adder: recombine the partial products one bit wider than the
  // result. The top bit is provably zero and is dropped at the register.
  assign sum = {{(WIDTH+1){1'b0}}, pp0_q}
             + (({{(WIDTH+1){1'b0}}, pp1_q} + {{(WIDTH+1){1'b0}}, pp2_q}) << H)
             + ({{(WIDTH+1){1'b0}}, pp3_q} << WIDTH);
  assign {unusedTop, prod_d} = sumSigned;

  // S3 result register. It holds Q steady for as long as the consumer stalls.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      prod_q    <= '0;
      s3Valid_q <= 1'b0;
    end else if (advance) begin
      prod_q    <= prod_d;
      s3Valid_q <= s2Valid_q;
    end
  end

  assign Q         = prod_q;
  assign out_valid = s3Valid_q;
  assign busy      = s1Valid_q | s2Valid_q | s3Valid_q;

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Directed testbench for vedic_mul_pipe. The main DUT runs at WIDTH=8.
// Three extra instances cover WIDTH=4, 16 and 32. Inputs change 1 time unit
// after the rising edge, and outputs are read at that same point.
module tb_vedic_mul_pipe;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        in_valid;
  logic        out_ready;
  logic        op_signed;
  logic        in_ready;
  logic [15:0] Q;
  logic        out_valid;
  logic        busy;

  logic [3:0]  a4, b4;
  logic [7:0]  q4;
  logic        iv4, ir4, ov4, busy4;
  logic [15:0] a16, b16;
  logic [31:0] q16;
  logic        iv16, ir16, ov16, busy16;
  logic [31:0] a32, b32;
  logic [63:0] q32;
  logic        iv32, ir32, ov32, busy32;

  int checks = 0;
  int fails  = 0;

  always #5 CLK = ~CLK;

  vedic_mul_pipe #(.WIDTH(8)) dut (
    .CLK(CLK), .RST_n(RST_n), .A(A), .B(B), .in_valid(in_valid),
    .in_ready(in_ready),
`ifdef VEDIC_SIGNED_EN
    .op_signed(op_signed),
`endif
    .Q(Q), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  vedic_mul_pipe #(.WIDTH(4)) dut4 (
    .CLK(CLK), .RST_n(RST_n), .A(a4), .B(b4), .in_valid(iv4), .in_ready(ir4),
`ifdef VEDIC_SIGNED_EN
    .op_signed(1'b0),
`endif
    .Q(q4), .out_valid(ov4), .out_ready(1'b1), .busy(busy4)
  );

  vedic_mul_pipe #(.WIDTH(16)) dut16 (
    .CLK(CLK), .RST_n(RST_n), .A(a16), .B(b16), .in_valid(iv16), .in_ready(ir16),
`ifdef VEDIC_SIGNED_EN
    .op_signed(1'b0),
`endif
    .Q(q16), .out_valid(ov16), .out_ready(1'b1), .busy(busy16)
  );

  vedic_mul_pipe #(.WIDTH(32)) dut32 (
    .CLK(CLK), .RST_n(RST_n), .A(a32), .B(b32), .in_valid(iv32), .in_ready(ir32),
`ifdef VEDIC_SIGNED_EN
    .op_signed(1'b0),
`endif
    .Q(q32), .out_valid(ov32), .out_ready(1'b1), .busy(busy32)
  );

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Let the pipe drain with the consumer ready and no new input.
  task automatic drain;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
  endtask

  task automatic test_reset;
    RST_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; op_signed = 1'b0;
    a4 = '0; b4 = '0; iv4 = 1'b0; a16 = '0; b16 = '0; iv16 = 1'b0;
    a32 = '0; b32 = '0; iv32 = 1'b0;
    #3;
    checks++; if (Q !== 16'h0) begin fails++; $display("[TB] FAIL rst_q: got %h expected 0000", Q); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
    repeat (2) tick();
    RST_n = 1'b1;
    tick();
    // Put three products in flight, then reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) begin
      A = 8'(i + 2); B = 8'd7; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2 RST_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (Q !== 16'h0) begin fails++; $display("[TB] FAIL midrst_q: got %h expected 0000", Q); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midrst_in_ready: got %b expected 1", in_ready); end
    repeat (2) tick();
    RST_n = 1'b1;
    tick();
    // A fresh pair presented for one edge must show up on the third edge.
    A = 8'd3; B = 8'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL post_rst_early: got %b expected 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL post_rst_valid: got %b expected 1", out_valid); end
    checks++; if (Q !== 16'd12) begin fails++; $display("[TB] FAIL post_rst_q: got %h expected 000c", Q); end
    tick();
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL post_rst_no_replay: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL post_rst_busy: got %b expected 0", busy); end
  endtask

  task automatic test_unsigned_corners;
    logic [7:0]  ta [4];
    logic [7:0]  tb [4];
    logic [15:0] te [4];
    ta = '{8'h00, 8'hFF, 8'h0F, 8'hAB};
    tb = '{8'h5A, 8'hFF, 8'h10, 8'hCD};
    te = '{16'h0000, 16'hFE01, 16'h00F0, 16'h88EF};
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) begin A = ta[c]; B = tb[c]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick();
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || Q !== te[c-2]) begin
          fails++;
          $display("[TB] FAIL corner_%0d: got valid=%b q=%h expected valid=1 q=%h", c - 2, out_valid, Q, te[c-2]);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL corner_lat_%0d: got %b expected 0", c, out_valid); end
      end
    end
    drain();
  endtask

  task automatic test_backpressure;
    logic [7:0]  va [10];
    logic [7:0]  vb [10];
    logic [15:0] expq [$];
    logic [15:0] prevQ;
    logic [15:0] want;
    logic        prevStall;
    logic        stallNow;
    int          sent;
    int          recv;
    int          cyc;
    sent = 0; recv = 0; cyc = 0; prevStall = 1'b0; prevQ = '0;
    for (int i = 0; i < 10; i++) begin
      va[i] = 8'($urandom_range(0, 255));
      vb[i] = 8'($urandom_range(0, 255));
    end
    while (recv < 10 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      if (sent < 10) begin A = va[sent]; B = vb[sent]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      #1;
      stallNow = out_valid && !out_ready;
      checks++;
      if (in_ready !== !stallNow) begin
        fails++; $display("[TB] FAIL bp_in_ready cyc %0d: got %b expected %b", cyc, in_ready, !stallNow);
      end
      if (prevStall) begin
        checks++;
        if (Q !== prevQ || out_valid !== 1'b1) begin
          fails++; $display("[TB] FAIL bp_q_stable cyc %0d: got %h expected %h", cyc, Q, prevQ);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          fails++; $display("[TB] FAIL bp_extra_output cyc %0d: got %h expected none", cyc, Q);
        end else begin
          want = expq.pop_front();
          if (Q !== want) begin
            fails++; $display("[TB] FAIL bp_order item %0d: got %h expected %h", recv, Q, want);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        expq.push_back({8'h00, va[sent]} * {8'h00, vb[sent]});
        sent++;
      end
      prevStall = stallNow;
      prevQ     = Q;
      @(posedge CLK);
      #1;
      cyc++;
    end
    checks++;
    if (recv != 10 || sent != 10) begin
      fails++; $display("[TB] FAIL bp_count: got sent=%0d recv=%0d expected 10/10", sent, recv);
    end
    drain();
  endtask

  task automatic test_width_sweep;
    logic [7:0]  e4;
    logic [31:0] e16;
    logic [63:0] e32;
    for (int v = 0; v < 3; v++) begin
      if (v == 0) begin
        a4 = 4'hF; b4 = 4'hF; a16 = 16'hFFFF; b16 = 16'hFFFF; a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF;
        e4 = 8'hE1; e16 = 32'hFFFE0001; e32 = 64'hFFFFFFFE00000001;
      end else if (v == 1) begin
        a4 = 4'h7; b4 = 4'h6; a16 = 16'h1234; b16 = 16'h5678; a32 = 32'h00010000; b32 = 32'h00010001;
        e4 = 8'h2A; e16 = 32'h06260060; e32 = 64'h0000000100010000;
      end else begin
        a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
        a16 = 16'($urandom); b16 = 16'($urandom); a32 = $urandom; b32 = $urandom;
        e4 = {4'h0, a4} * {4'h0, b4};
        e16 = {16'h0, a16} * {16'h0, b16};
        e32 = {32'h0, a32} * {32'h0, b32};
      end
      iv4 = 1'b1; iv16 = 1'b1; iv32 = 1'b1;
      tick();
      iv4 = 1'b0; iv16 = 1'b0; iv32 = 1'b0;
      repeat (2) tick();
      checks++; if (ov4 !== 1'b1 || q4 !== e4) begin fails++; $display("[TB] FAIL w4_%0d: got %b/%h expected 1/%h", v, ov4, q4, e4); end
      checks++; if (ov16 !== 1'b1 || q16 !== e16) begin fails++; $display("[TB] FAIL w16_%0d: got %b/%h expected 1/%h", v, ov16, q16, e16); end
      checks++; if (ov32 !== 1'b1 || q32 !== e32) begin fails++; $display("[TB] FAIL w32_%0d: got %b/%h expected 1/%h", v, ov32, q32, e32); end
      tick();
      checks++;
      if ({busy4, busy16, busy32} !== 3'b000 || {ir4, ir16, ir32} !== 3'b111) begin
        fails++; $display("[TB] FAIL wsweep_idle_%0d: got busy=%b ready=%b expected 000/111", v, {busy4, busy16, busy32}, {ir4, ir16, ir32});
      end
    end
  endtask

`ifdef VEDIC_SIGNED_EN
  task automatic test_signed;
    logic [7:0]  ta [8];
    logic [7:0]  tb [8];
    logic        ts [8];
    logic [15:0] te [8];
    ta = '{8'hFF, 8'h80, 8'h80, 8'h05, 8'hFF, 8'h80, 8'h80, 8'h05};
    tb = '{8'h01, 8'h80, 8'h7F, 8'hFD, 8'h01, 8'h80, 8'h7F, 8'hFD};
    ts = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    te = '{16'hFFFF, 16'h4000, 16'hC080, 16'hFFF1, 16'h00FF, 16'h4000, 16'h3F80, 16'h04F1};
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin A = ta[c]; B = tb[c]; op_signed = ts[c]; in_valid = 1'b1; end
      else in_valid = 1'b0;
      tick();
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || Q !== te[c-2]) begin
          fails++; $display("[TB] FAIL signed_%0d: got valid=%b q=%h expected valid=1 q=%h", c - 2, out_valid, Q, te[c-2]);
        end
      end
    end
    op_signed = 1'b0;
    drain();
  endtask
`endif

  task automatic test_bubbles;
    logic        pat [4];
    logic        expV;
    logic        expB;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c < 4) ? pat[c] : 1'b0;
      A = 8'(c + 2); B = 8'd3;
      tick();
      expV = (c >= 2 && c < 6) ? pat[c-2] : 1'b0;
      expB = (c + 1 <= 6);
      checks++;
      if (out_valid !== expV) begin
        fails++; $display("[TB] FAIL bubble_valid_%0d: got %b expected %b", c, out_valid, expV);
      end
      if (expV) begin
        checks++;
        if (Q !== 16'(c * 3)) begin
          fails++; $display("[TB] FAIL bubble_q_%0d: got %h expected %h", c, Q, 16'(c * 3));
        end
      end
      checks++;
      if (busy !== expB) begin
        fails++; $display("[TB] FAIL bubble_busy_%0d: got %b expected %b", c, busy, expB);
      end
    end
    drain();
  endtask

  initial begin
    test_reset();
    drain();
    test_unsigned_corners();
    test_backpressure();
    test_width_sweep();
`ifdef VEDIC_SIGNED_EN
    test_signed();
`endif
    test_bubbles();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
